// File: rtl/instr_encoder.sv
// Program loader: encodes decoded instruction fields into RV32I words and writes them to instruction memory.
// Optional NOP padding of the remaining memory on flush is built when INSTR_ENC_FLUSH_PAD_EN is defined.
module instr_encoder #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [20:0]       in_imm,
    input  logic              flush,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

`ifdef INSTR_ENC_FLUSH_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    localparam logic [2:0] CLS_LW  = 3'd0;
    localparam logic [2:0] CLS_SW  = 3'd1;
    localparam logic [2:0] CLS_R   = 3'd2;
    localparam logic [2:0] CLS_BEQ = 3'd3;
    localparam logic [2:0] CLS_I   = 3'd4;
    localparam logic [2:0] CLS_JAL = 3'd5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {IDLE, ENC, WRITE, PAD, FULL} state_t;

    state_t             state;
    logic [2:0]         fieldCls;
    logic [4:0]         fieldRd;
    logic [4:0]         fieldRs1;
    logic [4:0]         fieldRs2;
    logic [2:0]         fieldF3;
    logic [6:0]         fieldF7;
    logic signed [20:0] fieldImm;
    logic               lastSlot;

    // Illegal class, or an immediate the target format cannot represent.
    function automatic logic isIllegal(input logic [2:0] cls, input logic signed [20:0] imm);
        logic bad;
        bad = 1'b0;
        case (cls)
            CLS_LW, CLS_SW, CLS_I: bad = (imm < -21'sd2048) || (imm > 21'sd2047);
            CLS_BEQ:               bad = imm[0] || (imm < -21'sd4096) || (imm > 21'sd4094);
            CLS_R:                 bad = 1'b0;
            CLS_JAL:               bad = imm[0];
            default:               bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] encode(
        input logic [2:0]         cls,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [20:0] imm
    );
        logic [31:0] w;
        w = NOP;
        case (cls)
            CLS_LW:  w = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            CLS_SW:  w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            CLS_R:   w = {f7, rs2, rs1, f3, rd, OP_R};
            CLS_BEQ: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BR};
            CLS_I: begin
                // Shifts carry funct7 in the upper bits and only a 5-bit shamt.
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {f7, imm[4:0], rs1, f3, rd, OP_IMM};
                else
                    w = {imm[11:0], rs1, f3, rd, OP_IMM};
            end
            CLS_JAL: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default: w = NOP;
        endcase
        return w;
    endfunction

    assign lastSlot = (count == LAST_IDX);
    assign in_ready = (state == IDLE);
    assign done     = (state == FULL);

    // Captured request fields; data only, so no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            fieldCls <= in_cls;
            fieldRd  <= in_rd;
            fieldRs1 <= in_rs1;
            fieldRs2 <= in_rs2;
            fieldF3  <= in_funct3;
            fieldF7  <= in_funct7;
            fieldImm <= in_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            im_we    <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= ENC;
                    end else if (PAD_EN && flush) begin
                        state    <= PAD;
                        im_we    <= 1'b1;
                        im_wdata <= NOP;
                    end
                end
                ENC: begin
                    if (isIllegal(fieldCls, fieldImm)) begin
                        im_wdata <= NOP;
                        err      <= 1'b1;
                    end else begin
                        im_wdata <= encode(fieldCls, fieldRd, fieldRs1, fieldRs2,
                                           fieldF3, fieldF7, fieldImm);
                    end
                    im_we <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    im_we <= 1'b0;
                    count <= count + ONE;
                    // The address stays on the last written word once memory is full.
                    if (lastSlot) begin
                        state <= FULL;
                    end else begin
                        im_addr <= im_addr + 32'd4;
                        state   <= IDLE;
                    end
                end
                PAD: begin
                    count <= count + ONE;
                    if (lastSlot) begin
                        im_we <= 1'b0;
                        state <= FULL;
                    end else begin
                        im_addr <= im_addr + 32'd4;
                    end
                end
                FULL: state <= FULL;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=2): directed requests push expected writes, a monitor pops and compares.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_cls;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [20:0]   in_imm;
    logic          flush;
    logic          im_we;
    logic [31:0]   im_addr, im_wdata;
    logic [AW:0]   count;
    logic          done, err;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .flush(flush), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    int          nChecks = 0;
    int          nFail   = 0;
    int          cyc     = 0;
    logic [31:0] nextAddr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            nFail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_write: got addr %h data %h, want no write", im_addr, im_wdata);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check32("wr_addr", im_addr, e.addr);
                check32("wr_data", im_wdata, e.data);
                check32("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            nChecks++;
            nFail++;
            $display("FAIL ready_timeout: got in_ready %b, want 1", in_ready);
        end
    endtask

    task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [20:0] imm, input logic [31:0] wantData, input bit expectWrite);
        waitReady();
        in_cls    = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (expectWrite) begin
            expQ.push_back('{nextAddr, wantData, cyc + 1});
            nextAddr += 32'd4;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        nextAddr = 32'h0;
        check32("pending_before_reset", 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    task automatic checkResetState();
        check32("rst_in_ready", 32'(in_ready), 32'd1);
        check32("rst_im_we", 32'(im_we), 32'd0);
        check32("rst_im_addr", im_addr, 32'h0);
        check32("rst_im_wdata", im_wdata, 32'h0);
        check32("rst_count", 32'(count), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        in_cls = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        nextAddr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetState();

        // lw x5,8(x2); beq x0,x0,4094; sw x2,-4(x3)
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 21'd8, 32'h0081_2283, 1'b1);
        send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd4094, 32'h7E00_0FE3, 1'b1);
        send(3'd1, 5'd0, 5'd3, 5'd2, 3'd0, 7'd0, 21'(-4), 32'hFE21_AE23, 1'b1);
        waitReady();
        check32("blk1_count", 32'(count), 32'd3);
        check32("blk1_err", 32'(err), 32'd0);

        // add, beq -8, srai, illegal class 7; then memory is full
        doReset();
        checkResetState();
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 32'h0020_81B3, 1'b1);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'(-8), 32'hFE20_8CE3, 1'b1);
        waitReady();
        check32("blk2_count2", 32'(count), 32'd2);
        check32("blk2_err0", 32'(err), 32'd0);
        send(3'd4, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 21'd3, 32'h4031_5093, 1'b1);
        send(3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 21'd0, 32'h0000_0013, 1'b1);
        waitCycles(3);
        check32("full_done", 32'(done), 32'd1);
        check32("full_in_ready", 32'(in_ready), 32'd0);
        check32("full_count", 32'(count), 32'd4);
        check32("full_addr", im_addr, 32'hC);
        check32("full_err", 32'(err), 32'd1);
        in_valid = 1'b1;
        waitCycles(5);
        in_valid = 1'b0;
        check32("full_count_after_req", 32'(count), 32'd4);

        // jal x1,16; sw imm 2048 (err); addi x1,x0,-2048; beq odd (err)
        doReset();
        checkResetState();
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd16, 32'h0100_00EF, 1'b1);
        send(3'd1, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'd2048, 32'h0000_0013, 1'b1);
        waitReady();
        check32("sw_range_err", 32'(err), 32'd1);
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(-2048), 32'h8000_0093, 1'b1);
        waitReady();
        check32("err_sticky", 32'(err), 32'd1);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'd5, 32'h0000_0013, 1'b1);
        waitCycles(3);
        check32("blk3_done", 32'(done), 32'd1);

        // Reset while in ENC discards the pending word
        doReset();
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 21'd8, 32'h0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetState();
        waitCycles(3);
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 32'h0020_81B3, 1'b1);
        waitReady();
        check32("after_enc_reset_count", 32'(count), 32'd1);

        // Flush after one instruction
        doReset();
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 21'd8, 32'h0081_2283, 1'b1);
        waitReady();
`ifdef INSTR_ENC_FLUSH_PAD_EN
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back('{nextAddr, 32'h0000_0013, cyc + i});
            nextAddr += 32'd4;
        end
        waitCycles(4);
        check32("pad_done", 32'(done), 32'd1);
        check32("pad_count", 32'(count), 32'd4);
        check32("pad_addr", im_addr, 32'hC);
`else
        flush = 1'b1;
        waitCycles(6);
        flush = 1'b0;
        check32("noflush_count", 32'(count), 32'd1);
        check32("noflush_done", 32'(done), 32'd0);
        check32("noflush_ready", 32'(in_ready), 32'd1);
`endif

        waitCycles(3);
        check32("queue_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
